ganglion_scheduler: RTL and testbench
=====================================

GANGLION_SCHEDULER -- requirements
Module: ganglion_scheduler

Interface
REQ-001 Parameter DIST_W, default 100: width of each distance bus.
REQ-002 Parameter WIN_CYC, default 50000000: clock cycles per measurement window.
REQ-003 Parameter N_WIN, default 8: windows per granted run, range 1..127.
REQ-004 Parameter TO_CYC, default WIN_CYC+64: drain timeout in cycles.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  2  per-channel measurement request, level, held until ack.
REQ-008 dist0, dist1  in  DIST_W each  channel distance buses.
REQ-009 dir0, dir1  in  1 each  channel direction select: 1 = ascending count, 0 = descending.
REQ-010 gang_dist  out  DIST_W  distance routed to the shared ganglion datapath.
REQ-011 gang_start  out  1  run enable to the shared datapath.
REQ-012 gang_dir  out  1  direction select to the shared datapath.
REQ-013 gang_done  in  1  one-cycle pulse from the datapath when colrcode/flat are valid.
REQ-014 gang_flat  in  7; gang_colr  in  1  datapath result.
REQ-015 grant  out  2  one-hot owner of the datapath, 00 when idle.
REQ-016 ack  out  2  one-cycle per-channel completion pulse.
REQ-017 res_flat  out  7; res_colr  out  1  registered result, valid when ack is nonzero.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 timeout_err  out  1  sticky, set on drain timeout, cleared only by reset.

Function
REQ-020 States SHALL be IDLE, GRANT, RUN, DRAIN, PUBLISH, all registered.
REQ-021 IDLE: if any req bit is set, go to GRANT next cycle; otherwise stay.
REQ-022 Arbitration SHALL be round-robin: a last-served pointer, reset to 1, gives priority to the other channel; when both request, the channel not last served wins.
REQ-023 A lone requester SHALL be granted regardless of the pointer.
REQ-024 GRANT: latch the winner into grant; drive gang_dist and gang_dir from the winner's bus; clear the window and cycle counters; go to RUN.
REQ-025 gang_dist and gang_dir SHALL follow the granted channel combinationally from grant, and SHALL be zero when grant is 00.
REQ-026 RUN: gang_start = 1.
REQ-027 RUN: the cycle counter increments each cycle and wraps at WIN_CYC-1 with a window-counter increment.
REQ-028 RUN: when the window counter reaches N_WIN, go to DRAIN; RUN therefore lasts exactly N_WIN*WIN_CYC cycles.
REQ-029 RUN: if the granted req bit drops, go to DRAIN immediately with an abort flag set.
REQ-030 DRAIN: gang_start = 0; wait for gang_done; the cycle counter restarts at 0.
REQ-031 DRAIN: on gang_done, capture gang_flat/gang_colr into res_flat/res_colr unless aborted, then go to PUBLISH.
REQ-032 DRAIN: if TO_CYC cycles elapse without gang_done, set timeout_err, leave res_* unchanged, and go to PUBLISH with abort set.
REQ-033 PUBLISH: if not aborted, pulse ack for the granted channel; update the last-served pointer in either case; clear grant and abort; go to IDLE.
REQ-034 gang_done outside DRAIN SHALL be ignored.
REQ-035 A req bit rising while the other channel is being served SHALL be held pending, never dropped.
REQ-036 ack SHALL never be high for both channels in the same cycle.
REQ-037 The counters SHALL be sized to hold WIN_CYC-1, N_WIN, and TO_CYC without overflow.

Reset
REQ-038 rst_n low SHALL force the following immediately, even mid-RUN:
- state IDLE
- grant 00, ack 00
- gang_start 0
- res_flat 0, res_colr 0
- busy 0, timeout_err 0
- all counters 0
- pointer 1
REQ-039 After rst_n rises, the first grant SHALL occur no earlier than the second rising edge.

Verification (WIN_CYC=10, N_WIN=2, TO_CYC=40)
REQ-040 req=01; gang_done pulses with flat=5, colr=1 three cycles after gang_start falls -> grant=01, gang_start high exactly 20 cycles, ack=01 with res_flat=5, res_colr=1.
REQ-041 req=11 held across three runs -> grants in order 01, 10, 01; the ack sequence matches.
REQ-042 req0 dropped 7 cycles into RUN -> gang_start falls the next cycle; no ack; res_* unchanged; then channel 1 is served if it is requesting.
REQ-043 gang_done withheld -> timeout_err=1 after 40 DRAIN cycles; no ack; return to IDLE; timeout_err stays 1.
REQ-044 rst_n pulsed low mid-RUN -> all outputs at reset values asynchronously; the next run starts cleanly with full 20-cycle gang_start.
REQ-045 dir1=1, dist1=0x3F with grant=10 -> gang_dir=1 and gang_dist=0x3F; with grant=00 -> gang_dist=0, gang_dir=0.

Source files
------------

// File: rtl/ganglion_scheduler.sv
// Two-channel round-robin scheduler that time-shares one ganglion datapath:
// it runs the granted channel for N_WIN windows, drains the result and publishes it.
module ganglion_scheduler #(
  parameter int DIST_W  = 100,
  parameter int WIN_CYC = 50000000,
  parameter int N_WIN   = 8,
  parameter int TO_CYC  = WIN_CYC + 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DIST_W-1:0] dist0,
  input  logic [DIST_W-1:0] dist1,
  input  logic              dir0,
  input  logic              dir1,
  output logic [DIST_W-1:0] gang_dist,
  output logic              gang_start,
  output logic              gang_dir,
  input  logic              gang_done,
  input  logic [6:0]        gang_flat,
  input  logic              gang_colr,
  output logic [1:0]        grant,
  output logic [1:0]        ack,
  output logic [6:0]        res_flat,
  output logic              res_colr,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        o_dbg_state
);

  localparam int CYC_MAX = (TO_CYC > WIN_CYC) ? TO_CYC : WIN_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int WIN_W   = $clog2(N_WIN + 1);
  localparam logic [CYC_W-1:0] CYC_WIN_LAST = CYC_W'(WIN_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_TO_LAST  = CYC_W'(TO_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST     = WIN_W'(N_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_PUBLISH = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_grant;
  logic [1:0]        r_ack;
  logic              r_start;
  logic [6:0]        r_flat;
  logic              r_colr;
  logic              r_terr;
  logic              r_abort;
  logic              r_last;
  logic [CYC_W-1:0]  r_cyc;
  logic [WIN_W-1:0]  r_win;

  logic              w_pick1;
  logic [1:0]        w_win;
  logic [DIST_W-1:0] w_dist;
  logic              w_dir;

  // Handshake: a requester holds its req bit high until it sees its ack pulse.
  // ack is one cycle wide (during PUBLISH) and res_* are stable while it is high;
  // an aborted or timed-out run ends with no ack at all.

  // r_last names the channel served most recently, so the other one wins a tie.
  assign w_pick1 = req[1] & (~req[0] | ~r_last);
  assign w_win   = w_pick1 ? 2'b10 : (req[0] ? 2'b01 : 2'b00);

  always_comb begin
    w_dist = '0;
    w_dir  = 1'b0;
    if (r_grant[0]) begin
      w_dist = dist0;
      w_dir  = dir0;
    end else if (r_grant[1]) begin
      w_dist = dist1;
      w_dir  = dir1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_ack   <= 2'b00;
      r_start <= 1'b0;
      r_flat  <= 7'd0;
      r_colr  <= 1'b0;
      r_terr  <= 1'b0;
      r_abort <= 1'b0;
      r_last  <= 1'b1;
      r_cyc   <= '0;
      r_win   <= '0;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) r_state <= S_GRANT;
        end
        S_GRANT: begin
          r_cyc   <= '0;
          r_win   <= '0;
          r_abort <= 1'b0;
          if (w_win != 2'b00) begin
            r_grant <= w_win;
            r_start <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if ((req & r_grant) == 2'b00) begin
            r_abort <= 1'b1;
            r_start <= 1'b0;
            r_cyc   <= '0;
            r_state <= S_DRAIN;
          end else if (r_cyc == CYC_WIN_LAST) begin
            r_cyc <= '0;
            r_win <= r_win + WIN_W'(1);
            if (r_win == WIN_LAST) begin
              r_start <= 1'b0;
              r_state <= S_DRAIN;
            end
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        S_DRAIN: begin
          if (gang_done) begin
            if (!r_abort) begin
              r_flat <= gang_flat;
              r_colr <= gang_colr;
              r_ack  <= r_grant;
            end
            r_state <= S_PUBLISH;
          end else if (r_cyc == CYC_TO_LAST) begin
            r_terr  <= 1'b1;
            r_abort <= 1'b1;
            r_state <= S_PUBLISH;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        S_PUBLISH: begin
          r_last  <= r_grant[1];
          r_grant <= 2'b00;
          r_abort <= 1'b0;
          r_cyc   <= '0;
          r_win   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gang_dist   = w_dist;
  assign gang_dir    = w_dir;
  assign gang_start  = r_start;
  assign grant       = r_grant;
  assign ack         = r_ack;
  assign res_flat    = r_flat;
  assign res_colr    = r_colr;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ganglion_scheduler.sv
// Randomized bench for ganglion_scheduler; expectations come from a transaction-level
// model of arbitration, run length, drain/timeout timing and result publishing.
module tb_ganglion_scheduler;

  localparam int DIST_W  = 16;
  localparam int WIN_CYC = 10;
  localparam int N_WIN   = 2;
  localparam int TO_CYC  = 40;
  localparam int RUN_LEN = N_WIN * WIN_CYC;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req;
  logic [DIST_W-1:0] dist0, dist1;
  logic              dir0, dir1;
  logic [DIST_W-1:0] gang_dist;
  logic              gang_start, gang_dir;
  logic              gang_done;
  logic [6:0]        gang_flat;
  logic              gang_colr;
  logic [1:0]        grant, ack;
  logic [6:0]        res_flat;
  logic              res_colr;
  logic              busy, timeout_err;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic       m_last;
  logic [6:0] m_flat;
  logic       m_colr;
  logic       m_terr;
  logic [9:0] exp_q[$];

  ganglion_scheduler #(
    .DIST_W(DIST_W), .WIN_CYC(WIN_CYC), .N_WIN(N_WIN), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dist0(dist0), .dist1(dist1), .dir0(dir0), .dir1(dir1),
    .gang_dist(gang_dist), .gang_start(gang_start), .gang_dir(gang_dir),
    .gang_done(gang_done), .gang_flat(gang_flat), .gang_colr(gang_colr),
    .grant(grant), .ack(ack), .res_flat(res_flat), .res_colr(res_colr),
    .busy(busy), .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_flat = 7'd0;
    m_colr = 1'b0;
    m_terr = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_grant"}, grant, 0);
    chk({pfx, "_ack"}, ack, 0);
    chk({pfx, "_start"}, gang_start, 0);
    chk({pfx, "_res_flat"}, res_flat, 0);
    chk({pfx, "_res_colr"}, res_colr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_terr"}, timeout_err, 0);
    chk({pfx, "_dist"}, gang_dist, 0);
    chk({pfx, "_dir"}, gang_dir, 0);
  endtask

  // Driver for one transaction, entered and left at a negedge with the DUT idle.
  // drop_k > 0 drops the winner's req after drop_k run cycles; done_d < 0 withholds gang_done.
  task automatic run_txn(input logic [1:0] reqs, input int drop_k, input int done_d,
                         input logic [6:0] flat, input logic colr);
    int wait_n, hi, n, exp_drain;
    logic [1:0] win;
    logic [9:0] e;
    logic timeout;
    req = reqs;
    win = (reqs == 2'b11) ? (m_last ? 2'b01 : 2'b10) : reqs;
    timeout = (done_d < 0);
    wait_n = 0;
    while (grant == 2'b00 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("grant_latency", wait_n, 2);
    if (grant == 2'b00) return;
    chk("grant", grant, win);
    chk("gang_dist", gang_dist, win[0] ? dist0 : dist1);
    chk("gang_dir", gang_dir, win[0] ? dir0 : dir1);
    chk("busy_run", busy, 1);

    // run phase, with stray gang_done pulses and garbage results that must be ignored
    hi = 0;
    while (gang_start && hi < 200) begin
      hi++;
      gang_done = ($urandom_range(0, 3) == 0);
      gang_flat = 7'($urandom);
      gang_colr = 1'($urandom);
      if (hi == drop_k) req = req & ~win;
      @(negedge clk);
    end
    chk("start_len", hi, (drop_k > 0) ? drop_k : RUN_LEN);

    // drain phase: this negedge is the first drain cycle
    gang_flat = flat;
    gang_colr = colr;
    gang_done = (done_d == 0);
    if (!timeout && drop_k == 0) exp_q.push_back({win, flat, colr});
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      gang_done = 1'b0;
      n++;
      if (!busy) break;
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) chk("ack_unexpected", ack, 0);
        else begin
          e = exp_q.pop_front();
          chk("ack", ack, e[9:8]);
          chk("res_flat", res_flat, e[7:1]);
          chk("res_colr", res_colr, e[0]);
        end
      end
      gang_done = (!timeout && n == done_d + 1);
    end
    gang_done = 1'b0;
    exp_drain = (timeout ? TO_CYC : done_d + 1) + 2;
    chk("drain_len", n, exp_drain);
    chk("ack_missing", exp_q.size(), 0);
    exp_q.delete();

    if (!timeout && drop_k == 0) begin
      m_flat = flat;
      m_colr = colr;
    end
    if (timeout) m_terr = 1'b1;
    m_last = win[1];

    chk("res_flat_hold", res_flat, m_flat);
    chk("res_colr_hold", res_colr, m_colr);
    chk("timeout_err", timeout_err, m_terr);
    chk("grant_idle", grant, 0);
    chk("dist_idle", gang_dist, 0);
    chk("dir_idle", gang_dir, 0);
  endtask

  task automatic rand_bus();
    dist0 = 16'($urandom);
    dist1 = 16'($urandom);
    dir0  = 1'($urandom);
    dir1  = 1'($urandom);
  endtask

  initial begin
    int wait_n;
    int dk, dd;
    rst_n = 1'b0;
    req = 2'b00;
    gang_done = 1'b0;
    gang_flat = 7'd0;
    gang_colr = 1'b0;
    rand_bus();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // both channels requesting across three runs alternate
    repeat (3) begin
      rand_bus();
      run_txn(2'b11, 0, 3, 7'($urandom), 1'($urandom));
    end

    // single requester, done three cycles after start falls
    run_txn(2'b01, 0, 3, 7'd5, 1'b1);

    // channel 1 routing with known bus values
    dist1 = 16'h003F;
    dir1  = 1'b1;
    run_txn(2'b10, 0, 5, 7'h22, 1'b0);

    // channel 0 abandons its request mid-run; channel 1 is served next
    rand_bus();
    run_txn(2'b11, 7, 4, 7'h55, 1'b0);
    run_txn(2'b10, 0, 2, 7'h33, 1'b1);

    // latest accepted done, then a withheld done, then a normal run afterwards
    run_txn(2'b01, 0, TO_CYC - 1, 7'h7F, 1'b0);
    run_txn(2'b01, 0, -1, 7'h11, 1'b1);
    run_txn(2'b10, 0, 1, 7'h0A, 1'b1);

    for (int t = 0; t < 30; t++) begin
      rand_bus();
      dk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, RUN_LEN - 1) : 0;
      dd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO_CYC - 1);
      run_txn(2'($urandom_range(1, 3)), dk, dd, 7'($urandom), 1'($urandom));
    end

    // a completed run followed by asynchronous reset in the middle of the next run
    run_txn(2'b01, 0, 6, 7'h6C, 1'b1);
    req = 2'b01;
    wait_n = 0;
    while (grant == 2'b00 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("pre_reset_grant", grant, 2'b01);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rand_bus();
    run_txn(2'b01, 0, 3, 7'h2D, 1'b0);
    run_txn(2'b11, 0, 8, 7'h41, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
